// File: rtl/aes_pkg.sv
// Shared types, constants and the Rcon table for the AES-256 key expansion engine.
package aes_pkg;

  localparam logic [3:0] RK_FIRST_STEP = 4'd2;
  localparam logic [3:0] RK_LAST       = 4'd14;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rk_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Rcon values are used only by even steps k, indexed by k/2 (1..7).
  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes256_key_step.sv
// One combinational AES-256 key-schedule step: round key k from round keys k-2 and k-1.
module aes256_key_step
  import aes_pkg::*;
(
  input  rk_t        prev2,
  input  rk_t        prev1,
  input  logic [3:0] k,
  output rk_t        next_rk
);

  word_t t;
  word_t sel;
  word_t sub;
  word_t x;
  word_t n0, n1, n2, n3;

  assign t   = prev1[31:0];
  // Odd steps skip RotWord and Rcon; only SubWord is applied.
  assign sel = k[0] ? t : {t[23:0], t[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sel[8*i +: 8]),
      .y (sub[8*i +: 8])
    );
  end

  assign x  = sub ^ (k[0] ? 32'h0 : {rcon(k[3:1]), 24'h0});
  assign n0 = prev2[127:96] ^ x;
  assign n1 = prev2[95:64]  ^ n0;
  assign n2 = prev2[63:32]  ^ n1;
  assign n3 = prev2[31:0]   ^ n2;

  assign next_rk = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc;
    logic [7:0] m;
    acc = 8'h00;
    m   = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) acc = acc ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^(2+4+...+128) is the inverse, and maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  assign inv = gf_inv(a);
  assign y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes256_key_expander.sv
// Sequential AES-256 key expansion into a 15-entry round-key store with a registered read port.
// Handshake: a key is taken on any rising edge where key_valid && key_ready; key_valid while busy is dropped.
module aes256_key_expander
  import aes_pkg::*;
#(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  state_t     state, state_next;
  logic [3:0] k;
  logic       accept;
  logic       last;
  rk_t        prev2, prev1;
  rk_t        step_rk;
  rk_t        store [0:NR];

  aes256_key_step u_step (
    .prev2   (prev2),
    .prev1   (prev1),
    .k       (k),
    .next_rk (step_rk)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_valid) begin
          accept     = 1'b1;
          state_next = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (k == RK_LAST) begin
          last       = 1'b1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  assign key_ready = (state == ST_IDLE);
  assign busy      = (state == ST_EXPAND);

  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= 4'd0;
      done     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
    end else begin
      done <= last;
      if (accept)                          k <= RK_FIRST_STEP;
      else if (state == ST_EXPAND && !last) k <= k + 4'd1;
      if (accept)    rk_valid <= 1'b0;
      else if (last) rk_valid <= 1'b1;
      // Reads see the pre-edge store, so a same-edge write returns the old value.
      rk_data <= (rk_addr > RK_LAST) ? '0 : store[rk_addr];
    end
  end

  // Store and working registers are not reset; rk_valid alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        store[0] <= key_in[255:128];
        store[1] <= key_in[127:0];
        prev2    <= key_in[255:128];
        prev1    <= key_in[127:0];
      end else if (state == ST_EXPAND) begin
        store[k] <= step_rk;
        prev2    <= prev1;
        prev1    <= step_rk;
      end
    end
  end

endmodule
